// File: rtl/mem_arb_pkg.sv
// Shared types for the instruction/data main-memory arbiter.
//   state_t  : arbiter FSM states
//   req_id_t : requester identity (instruction or data side)
//   ST_*     : store-type encodings carried on d_storetype / mem_storetype
package mem_arb_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      MEM_I = 2'd1,
      MEM_D = 2'd2,
      RESP  = 2'd3
   } state_t;

   typedef enum logic {
      REQ_I = 1'b0,
      REQ_D = 1'b1
   } req_id_t;

   localparam logic [1:0] ST_BYTE = 2'b00;
   localparam logic [1:0] ST_HALF = 2'b01;
   localparam logic [1:0] ST_WORD = 2'b10;

endpackage

// File: rtl/mem_arbiter.sv
// Two-requester (instruction / data) arbiter in front of a single main-memory
// port. Round-robin on ties, one transaction at a time, with a wait timeout.
//
// Ports
//   clk, rst_n                         clock, async active-low reset
//   i_req, i_addr                      instruction-side line read request
//   i_ack, i_rdata                     instruction-side completion pulse / line
//   d_req, d_we, d_addr, d_wdata,
//   d_storetype                        data-side request (write or line read)
//   d_ack, d_rdata                     data-side completion pulse / line
//   err                                timeout pulse, coincident with the ack
//   busy                               high whenever not IDLE
//   mem_read, mem_write, mem_addr,
//   mem_wdata, mem_storetype           main-memory command (held until done)
//   mem_rdata, mem_done                main-memory response
//
// state | meaning
// ------+-------------------------------------------------------------
// IDLE  | waiting for a request; arbitration happens here
// MEM_I | instruction line read in flight, mem_read held
// MEM_D | data access in flight, mem_read or mem_write held
// RESP  | one-cycle ack to the owner (plus err after a timeout)
module mem_arbiter
   import mem_arb_pkg::*;
#(
   parameter int ADDR_W      = 10,
   parameter int LINE_W      = 128,
   parameter int TIMEOUT_CYC = 16
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              i_req,
   input  logic [ADDR_W-1:0] i_addr,
   output logic              i_ack,
   output logic [LINE_W-1:0] i_rdata,
   input  logic              d_req,
   input  logic              d_we,
   input  logic [ADDR_W-1:0] d_addr,
   input  logic [31:0]       d_wdata,
   input  logic [1:0]        d_storetype,
   output logic              d_ack,
   output logic [LINE_W-1:0] d_rdata,
   output logic              err,
   output logic              busy,
   output logic              mem_write,
   output logic              mem_read,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [31:0]       mem_wdata,
   output logic [1:0]        mem_storetype,
   input  logic [LINE_W-1:0] mem_rdata,
   input  logic              mem_done
);

   localparam int              CNT_W    = $clog2(TIMEOUT_CYC + 1);
   localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(TIMEOUT_CYC - 1);

   state_t           state, state_nxt;
   req_id_t          last_grant;   // also identifies the owner of the transaction in flight
   logic             we_q;
   logic             timeout_q;
   logic [CNT_W-1:0] wait_cnt;

   logic grant, grant_d, done_hit, tmo_hit;

   always_comb begin
      state_nxt = state;
      grant     = 1'b0;
      grant_d   = 1'b0;
      done_hit  = 1'b0;
      tmo_hit   = 1'b0;
      unique case (state)
         IDLE: begin
            if (i_req && d_req) begin
               grant   = 1'b1;
               grant_d = (last_grant == REQ_I);
            end else if (i_req) begin
               grant = 1'b1;
            end else if (d_req) begin
               grant   = 1'b1;
               grant_d = 1'b1;
            end
            if (grant) state_nxt = grant_d ? MEM_D : MEM_I;
         end
         MEM_I, MEM_D: begin
            // A completion in the final allowed cycle still counts as success.
            if (mem_done) begin
               done_hit  = 1'b1;
               state_nxt = RESP;
            end else if (wait_cnt == '0) begin
               tmo_hit   = 1'b1;
               state_nxt = RESP;
            end
         end
         RESP:    state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= IDLE;
      else        state <= state_nxt;
   end

   // Wait counter is a down-counter loaded at grant; terminal count is zero.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         last_grant    <= REQ_I;
         we_q          <= 1'b0;
         timeout_q     <= 1'b0;
         wait_cnt      <= '0;
         mem_addr      <= '0;
         mem_wdata     <= '0;
         mem_storetype <= '0;
         i_rdata       <= '0;
         d_rdata       <= '0;
      end else begin
         if (grant) begin
            last_grant <= grant_d ? REQ_D : REQ_I;
            wait_cnt   <= CNT_LOAD;
            timeout_q  <= 1'b0;
            if (grant_d) begin
               mem_addr      <= d_addr;
               mem_wdata     <= d_wdata;
               mem_storetype <= d_storetype;
               we_q          <= d_we;
            end else begin
               mem_addr <= i_addr;
               we_q     <= 1'b0;
            end
         end else if ((state == MEM_I || state == MEM_D) && wait_cnt != '0) begin
            wait_cnt <= wait_cnt - 1'b1;
         end
         if (tmo_hit) timeout_q <= 1'b1;
         if (done_hit) begin
            if (last_grant == REQ_D) d_rdata <= mem_rdata;
            else                     i_rdata <= mem_rdata;
         end
      end
   end

   // Outputs decode straight from registered state so reset clears them at once.
   assign busy      = (state != IDLE);
   assign mem_read  = (state == MEM_I) || ((state == MEM_D) && !we_q);
   assign mem_write = (state == MEM_D) && we_q;
   assign i_ack     = (state == RESP) && (last_grant == REQ_I);
   assign d_ack     = (state == RESP) && (last_grant == REQ_D);
   assign err       = (state == RESP) && timeout_q;

endmodule

// File: tb/tb_mem_arbiter.sv
module tb_mem_arbiter;
   import mem_arb_pkg::*;

   localparam int TMO = 16;

   logic         clk = 1'b0;
   logic         rst_n = 1'b0;
   logic         i_req = 1'b0, d_req = 1'b0, d_we = 1'b0;
   logic [9:0]   i_addr = '0, d_addr = '0;
   logic [31:0]  d_wdata = '0;
   logic [1:0]   d_storetype = '0;
   logic         i_ack, d_ack, err, busy, mem_write, mem_read;
   logic [127:0] i_rdata, d_rdata;
   logic [9:0]   mem_addr;
   logic [31:0]  mem_wdata;
   logic [1:0]   mem_storetype;
   logic [127:0] mem_rdata = '0;
   logic         mem_done;
   logic         rsp_done = 1'b0, inj_done = 1'b0;

   assign mem_done = rsp_done | inj_done;

   mem_arbiter #(.ADDR_W(10), .LINE_W(128), .TIMEOUT_CYC(TMO)) dut (
      .clk(clk), .rst_n(rst_n),
      .i_req(i_req), .i_addr(i_addr), .i_ack(i_ack), .i_rdata(i_rdata),
      .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
      .d_storetype(d_storetype), .d_ack(d_ack), .d_rdata(d_rdata),
      .err(err), .busy(busy), .mem_write(mem_write), .mem_read(mem_read),
      .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_storetype(mem_storetype),
      .mem_rdata(mem_rdata), .mem_done(mem_done)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;

   // Reference memory: 1024 words; a line is four consecutive words, low word first.
   logic [31:0]  w [1024];
   int           done_delay = 0;   // 0 = never complete
   int           scnt = 0;
   bit           last_d = 1'b0;
   logic [127:0] exp_ird = '0, exp_drd = '0;

   function automatic logic [127:0] line_of(input int a);
      return {w[(a+3)&1023], w[(a+2)&1023], w[(a+1)&1023], w[a&1023]};
   endfunction

   task automatic apply_store(input int a, input logic [31:0] wd, input logic [1:0] st);
      case (st)
         ST_BYTE: w[a&1023][7:0]  = wd[7:0];
         ST_HALF: w[a&1023][15:0] = wd[15:0];
         default: w[a&1023]       = wd;
      endcase
   endtask

   // Memory responder: completes after done_delay strobe cycles.
   always @(negedge clk) begin
      if (mem_read || mem_write) begin
         scnt = scnt + 1;
         if (done_delay > 0 && scnt == done_delay) begin
            if (mem_write) apply_store(int'(mem_addr), mem_wdata, mem_storetype);
            mem_rdata = line_of(int'(mem_addr));
            rsp_done  = 1'b1;
         end else begin
            mem_rdata = {$urandom, $urandom, $urandom, $urandom};
            rsp_done  = 1'b0;
         end
      end else begin
         scnt      = 0;
         rsp_done  = 1'b0;
         mem_rdata = {$urandom, $urandom, $urandom, $urandom};
      end
   end

   task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset(input bit ir, input bit dr);
      inj_done = 1'b0;
      @(negedge clk);
      rst_n = 1'b0;
      i_req = ir;
      d_req = dr;
      #1;
      chk("rst_ctl", {busy, mem_read, mem_write, i_ack, d_ack, err}, '0);
      chk("rst_mem", {mem_addr, mem_wdata, mem_storetype}, '0);
      chk("rst_irdata", i_rdata, '0);
      chk("rst_drdata", d_rdata, '0);
      @(negedge clk);
      rst_n = 1'b1;
      #1;
      chk("no_grant_before_edge", busy, 1'b0);
      last_d  = 1'b0;
      exp_ird = '0;
      exp_drd = '0;
      tick();
   endtask

   task automatic run_txn(input bit ir, input bit dr, input bit we,
                          input logic [9:0] ia, input logic [9:0] da,
                          input logic [31:0] wd, input logic [1:0] st,
                          input int dly, input bit exp_d, input string nm);
      int  rd_cyc, wr_cyc, both_cyc, exp_strb;
      bit  got, seen, exp_wr, ia_s, da_s, er_s;
      rd_cyc = 0; wr_cyc = 0; both_cyc = 0;
      got = 0; seen = 0; ia_s = 0; da_s = 0; er_s = 0;
      exp_wr   = exp_d && we;
      exp_strb = (dly == 0) ? TMO : dly;
      done_delay = dly;
      i_req = ir; d_req = dr; d_we = we;
      i_addr = ia; d_addr = da; d_wdata = wd; d_storetype = st;
      tick();
      chk({nm, "_strobe_n1"}, mem_read | mem_write, 1'b1);
      for (int c = 0; c < 40 && !got; c++) begin
         if (mem_read && mem_write) both_cyc++;
         if (mem_read || mem_write) begin
            if (!seen) begin
               seen = 1;
               chk({nm, "_addr"}, mem_addr, exp_d ? da : ia);
               if (exp_wr) chk({nm, "_wdata"}, {mem_storetype, mem_wdata}, {st, wd});
            end
            if (mem_read)  rd_cyc++;
            if (mem_write) wr_cyc++;
         end
         if (i_ack || d_ack) begin
            got = 1; ia_s = i_ack; da_s = d_ack; er_s = err;
         end else begin
            tick();
         end
      end
      chk({nm, "_ack_seen"}, got, 1'b1);
      chk({nm, "_ack_side"}, {ia_s, da_s}, {!exp_d, exp_d});
      chk({nm, "_err"}, er_s, dly == 0);
      chk({nm, "_rd_cycles"}, rd_cyc, exp_wr ? 0 : exp_strb);
      chk({nm, "_wr_cycles"}, wr_cyc, exp_wr ? exp_strb : 0);
      chk({nm, "_both_strobes"}, both_cyc, 0);
      if (dly != 0) begin
         if (exp_d) exp_drd = line_of(int'(da));
         else       exp_ird = line_of(int'(ia));
      end
      chk({nm, "_i_rdata"}, i_rdata, exp_ird);
      chk({nm, "_d_rdata"}, d_rdata, exp_drd);
      last_d = exp_d;
      i_req = 0; d_req = 0;
      tick();
      chk({nm, "_after"}, {busy, i_ack, d_ack, err}, '0);
   endtask

   task automatic wait_ack(output bit got);
      got = 0;
      for (int c = 0; c < 40 && !got; c++) begin
         if (i_ack || d_ack) got = 1;
         else tick();
      end
   endtask

   typedef struct {
      bit          ir, dr, we;
      logic [9:0]  ia, da;
      logic [31:0] wd;
      logic [1:0]  st;
      int          dly;
      bit          exp_d;
   } vec_t;

   vec_t tbl[9];

   initial begin
      int  ci, cd, first, viol;
      bit  got, ir, dr, we, ed;
      int  sel, dly;
      logic [1:0] st;

      for (int k = 0; k < 1024; k++) w[k] = (k * 32'h9E3779B1) ^ 32'h5A5A0000;

      tbl[0] = '{1, 0, 0, 10'h010, 10'h000, 32'h0,        ST_WORD, 4, 0};
      tbl[1] = '{0, 1, 1, 10'h000, 10'h044, 32'hDEADBEEF, ST_WORD, 3, 1};
      tbl[2] = '{1, 0, 0, 10'h044, 10'h000, 32'h0,        ST_WORD, 2, 0};
      tbl[3] = '{1, 1, 0, 10'h200, 10'h100, 32'h0,        ST_WORD, 1, 1};
      tbl[4] = '{1, 1, 0, 10'h3FE, 10'h155, 32'h0,        ST_WORD, 5, 0};
      tbl[5] = '{0, 1, 1, 10'h000, 10'h045, 32'h12345678, ST_BYTE, 2, 1};
      tbl[6] = '{0, 1, 1, 10'h000, 10'h046, 32'hCAFEF00D, ST_HALF, 1, 1};
      tbl[7] = '{0, 1, 0, 10'h000, 10'h0C0, 32'h0,        ST_WORD, 0, 1};
      tbl[8] = '{1, 1, 0, 10'h00F, 10'h0F0, 32'h0,        ST_WORD, 6, 0};

      do_reset(0, 0);
      for (int t = 0; t < 9; t++)
         run_txn(tbl[t].ir, tbl[t].dr, tbl[t].we, tbl[t].ia, tbl[t].da,
                 tbl[t].wd, tbl[t].st, tbl[t].dly, tbl[t].exp_d, $sformatf("tbl%0d", t));

      // Store results read back through the instruction side.
      run_txn(1, 0, 0, 10'h044, 10'h000, 32'h0, ST_WORD, 1, 0, "readback");
      chk("readback_word", i_rdata[31:0], 32'hDEADBEEF);
      chk("readback_byte", i_rdata[39:32], 8'h78);
      chk("readback_half", i_rdata[79:64], 16'hF00D);

      // Stray mem_done while idle is ignored.
      @(negedge clk); inj_done = 1'b1;
      tick();
      chk("stray_done_busy", busy, 1'b0);
      @(negedge clk); inj_done = 1'b0;
      tick();
      chk("stray_done_rdata", {i_rdata, d_rdata}, {exp_ird, exp_drd});

      // Request held after ack is a new request.
      done_delay = 1;
      i_addr = 10'h020; i_req = 1;
      tick();
      wait_ack(got);
      chk("hold_ack1", got, 1'b1);
      tick();
      chk("hold_idle_gap", busy, 1'b0);
      tick();
      chk("hold_regrant", {busy, mem_read}, 2'b11);
      i_req = 0;
      wait_ack(got);
      chk("hold_ack2", {got, i_ack}, 2'b11);
      exp_ird = line_of(10'h020);
      last_d  = 0;
      tick();

      // Request dropped mid-transaction still gets exactly one ack.
      done_delay = 5;
      i_addr = 10'h030; i_req = 1;
      tick(); tick();
      i_req = 0;
      wait_ack(got);
      chk("drop_ack", {got, i_ack, d_ack}, 3'b110);
      chk("drop_rdata", i_rdata, line_of(10'h030));
      exp_ird = line_of(10'h030);
      viol = 0;
      for (int c = 0; c < 10; c++) begin
         tick();
         if (busy || mem_read || mem_write || i_ack) viol++;
      end
      chk("drop_no_second", viol, 0);

      // Tie from reset: data side first, then instruction side.
      i_addr = 10'h111; d_addr = 10'h222; d_we = 0; done_delay = 2;
      do_reset(1, 1);
      ci = 0; cd = 0; first = -1;
      for (int c = 0; c < 60; c++) begin
         if (d_ack) begin cd++; if (first < 0) first = 1; d_req = 0; end
         if (i_ack) begin ci++; if (first < 0) first = 0; i_req = 0; end
         tick();
      end
      chk("tie_first_d", first, 1);
      chk("tie_d_acks", cd, 1);
      chk("tie_i_acks", ci, 1);
      chk("tie_rdata", {i_rdata, d_rdata}, {line_of(10'h111), line_of(10'h222)});
      exp_ird = line_of(10'h111);
      exp_drd = line_of(10'h222);
      last_d  = 0;

      // Asynchronous reset in the middle of a data transaction.
      done_delay = 0;
      d_req = 1; d_we = 0; d_addr = 10'h0AB;
      tick(); tick(); tick();
      chk("areset_pre_strobe", {busy, mem_read}, 2'b11);
      #2 rst_n = 1'b0;
      #1;
      chk("areset_ctl", {busy, mem_read, mem_write, i_ack, d_ack, err}, '0);
      chk("areset_mem", {mem_addr, mem_wdata, mem_storetype}, '0);
      chk("areset_rdata", {i_rdata, d_rdata}, '0);
      d_req = 0;
      @(negedge clk); rst_n = 1'b1;
      last_d = 0; exp_ird = '0; exp_drd = '0;
      tick();
      run_txn(1, 1, 0, 10'h033, 10'h066, 32'h0, ST_WORD, 2, 1, "post_reset_tie");

      // Randomised traffic against the reference model.
      for (int n = 0; n < 40; n++) begin
         sel = $urandom_range(1, 3);
         ir  = sel[0];
         dr  = sel[1];
         we  = $urandom_range(0, 1);
         st  = 2'($urandom_range(0, 2));
         dly = ($urandom_range(0, 7) == 0) ? 0 : $urandom_range(1, 6);
         ed  = (ir && dr) ? !last_d : dr;
         run_txn(ir, dr, we, 10'($urandom), 10'($urandom), $urandom, st, dly, ed,
                 $sformatf("rnd%0d", n));
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
